mem_map_ctrl: RTL

//  Parametrised memory-map controller between the CPU data/fetch port and the on-chip memories.

---
 rtl/mem_map_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: decodes one CPU port into IROM, DRAM, MMIO registers and unmapped space.
// Optional cycle counter after the MMIO block is enabled with `define MEMMAP_CYCLE_CNT_EN.
module mem_map_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int IROM_BASE = 0,
    parameter int IROM_SIZE = 4096,
    parameter int DRAM_BASE = 4096,
    parameter int DRAM_SIZE = 4096,
    parameter int IO_BASE   = 'hFFF0,
    parameter int NUM_IO    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memread_i,
    input  logic                     memwrite_i,
    input  logic [ADDR_W-1:0]        memaddr_i,
    input  logic [DATA_W-1:0]        memwdata_i,
    input  logic [DATA_W/8-1:0]      memwstrb_i,
    output logic [DATA_W-1:0]        memrdata_o,
    output logic                     memrvalid_o,
    output logic                     memerr_o,
    output logic [ADDR_W-3:0]        irom_addr_o,
    input  logic [DATA_W-1:0]        irom_rdata_i,
    output logic [DATA_W/8-1:0]      dram_we_o,
    output logic [ADDR_W-3:0]        dram_addr_o,
    output logic [DATA_W-1:0]        dram_wdata_o,
    input  logic [DATA_W-1:0]        dram_rdata_i,
    output logic [NUM_IO*DATA_W-1:0] io_regs_o
);
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_IROM,
        SEL_DRAM,
        SEL_IO,
        SEL_CNT
    } sel_t;

    logic [31:0] addr_ext;
    logic [31:0] irom_off;
    logic [31:0] dram_off;
    logic [31:0] io_off;
    logic [2:0]  io_idx;
    sel_t        region;
    logic        req;
    logic        fault;
    logic        wr_ok;
    logic        rd_any;
    logic        rd_ok;
    logic [DATA_W-1:0] cnt_word;
    logic [DATA_W-1:0] rd_word;

    sel_t              sel_reg;
    logic              rvalid_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rd_word_reg;

    // Offsets below a base wrap to huge values, so one unsigned compare bounds each window.
    assign addr_ext = 32'(memaddr_i);
    assign irom_off = addr_ext - 32'(IROM_BASE);
    assign dram_off = addr_ext - 32'(DRAM_BASE);
    assign io_off   = addr_ext - 32'(IO_BASE);
    assign io_idx   = io_off[4:2];

    always_comb begin
        region = SEL_NONE;
        if (irom_off < 32'(IROM_SIZE)) begin
            region = SEL_IROM;
        end else if (dram_off < 32'(DRAM_SIZE)) begin
            region = SEL_DRAM;
        end else if (io_off < 32'(4 * NUM_IO)) begin
            region = SEL_IO;
`ifdef MEMMAP_CYCLE_CNT_EN
        end else if (io_off[31:2] == 30'(NUM_IO)) begin
            region = SEL_CNT;
`endif
        end
    end

    assign req    = memread_i | memwrite_i;
    assign fault  = req && ((memaddr_i[1:0] != 2'b00) || (region == SEL_NONE) ||
                    (memwrite_i && ((region == SEL_IROM) || (memwstrb_i == '0))));
    assign wr_ok  = memwrite_i && !fault;
    assign rd_any = memread_i && !memwrite_i;
    assign rd_ok  = rd_any && !fault;

    assign irom_addr_o  = irom_off[ADDR_W-1:2];
    assign dram_addr_o  = dram_off[ADDR_W-1:2];
    assign dram_wdata_o = memwdata_i;
    assign dram_we_o    = (wr_ok && (region == SEL_DRAM)) ? memwstrb_i : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IO; gi++) begin : g_io
            logic [DATA_W-1:0] io_word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    io_word_reg <= '0;
                end else if (wr_ok && (region == SEL_IO) && (io_idx == 3'(gi))) begin
                    for (int b = 0; b < DATA_W / 8; b++) begin
                        if (memwstrb_i[b]) begin
                            io_word_reg[8*b +: 8] <= memwdata_i[8*b +: 8];
                        end
                    end
                end
            end
            assign io_regs_o[DATA_W*gi +: DATA_W] = io_word_reg;
        end
    endgenerate

`ifdef MEMMAP_CYCLE_CNT_EN
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (wr_ok && (region == SEL_CNT)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 32'd1;
        end
    end
    assign cnt_word = cnt_reg;
`else
    assign cnt_word = '0;
`endif

    assign rd_word = (region == SEL_CNT) ? cnt_word : io_regs_o[DATA_W*io_idx +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg  <= 1'b0;
            err_reg     <= 1'b0;
            sel_reg     <= SEL_NONE;
            rd_word_reg <= '0;
        end else begin
            rvalid_reg  <= rd_any;
            err_reg     <= fault;
            sel_reg     <= rd_ok ? region : SEL_NONE;
            rd_word_reg <= rd_word;
        end
    end

    // A response landing in a reset cycle is squashed so no stale read escapes.
    assign memrvalid_o = rvalid_reg && !rst;
    assign memerr_o    = err_reg && !rst;

    always_comb begin
        memrdata_o = '0;
        if (!rst) begin
            case (sel_reg)
                SEL_IROM:        memrdata_o = irom_rdata_i;
                SEL_DRAM:        memrdata_o = dram_rdata_i;
                SEL_IO, SEL_CNT: memrdata_o = rd_word_reg;
                default:         memrdata_o = '0;
            endcase
        end
    end
endmodule
